// File: rtl/pipe_sequencer.sv
// Control sequencer for the 4-stage IF/ID/EX/WB pipeline of the 2-bit-opcode core.
// Tracks per-stage instruction fields, decodes datapath controls, forwards operands, and runs halt/drain.
module pipe_sequencer #(
    parameter int RA_W     = 3,
    parameter int CNT_W    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_valid,
    input  logic [1:0]       if_op,
    input  logic [RA_W-1:0]  if_rd,
    input  logic [RA_W-1:0]  if_rs1,
    input  logic [RA_W-1:0]  if_rs2,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             pc_source,
    output logic             ex_alu_src,
    output logic             ex_alucntrl,
    output logic             wb_regwrite,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             byp_a,
    output logic             byp_b,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, state_next;

    logic            id_valid, ex_valid, wb_valid;
    logic [1:0]      id_op, ex_op, wb_op;
    logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
    logic [RA_W-1:0] ex_rd, ex_rs1, ex_rs2;
    logic [RA_W-1:0] wb_rd;

    logic fetch;
    logic pipe_empty;
    logic wb_fwd_ok;

    assign fsm_state = state;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus fetch/redirect control; a jump in EX overrides any fetch
    always_comb begin
        state_next = state;
        pc_source  = 1'b0;
        fetch      = 1'b0;
        pc_en      = 1'b0;
        halted     = 1'b0;
        pipe_empty = !id_valid && !ex_valid && !wb_valid;

        pc_source = ex_valid && (ex_op == OP_JUMP);
        fetch     = (state == RUN) && imem_valid && !pc_source;
        pc_en     = ((state == RUN) && imem_valid) || pc_source;
        halted    = (state == HALTED);

        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (halt_req) state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = HALTED;
            HALTED:  if (!halt_req) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Stage registers; bubbles carry zeroed fields so they can never match a forward
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid    <= 1'b0;
            id_op       <= '0;
            id_rd       <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            ex_valid    <= 1'b0;
            ex_op       <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            wb_valid    <= 1'b0;
            wb_op       <= '0;
            wb_rd       <= '0;
            retired_cnt <= '0;
        end else begin
            id_valid <= fetch;
            id_op    <= fetch ? if_op  : '0;
            id_rd    <= fetch ? if_rd  : '0;
            id_rs1   <= fetch ? if_rs1 : '0;
            id_rs2   <= fetch ? if_rs2 : '0;

            // A taken jump kills the instruction sitting in ID
            ex_valid <= id_valid && !pc_source;
            ex_op    <= pc_source ? '0 : id_op;
            ex_rd    <= pc_source ? '0 : id_rd;
            ex_rs1   <= pc_source ? '0 : id_rs1;
            ex_rs2   <= pc_source ? '0 : id_rs2;

            wb_valid <= ex_valid;
            wb_op    <= ex_op;
            wb_rd    <= ex_rd;

            if (wb_valid) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Per-stage decode, gated by the stage valid
    always_comb begin
        ex_alu_src  = ex_valid && ((ex_op == OP_SLL) || (ex_op == OP_JUMP));
        ex_alucntrl = ex_valid && (ex_op == OP_SLL);
        wb_regwrite = wb_valid && ((wb_op == OP_ADD) || (wb_op == OP_SLL));
    end

    // WB result is a forwarding source only when it really writes a non-r0 register
    always_comb begin
        wb_fwd_ok = wb_regwrite && !(ZERO_REG && (wb_rd == '0));
        fwd_a     = wb_fwd_ok && (wb_rd == ex_rs1);
        fwd_b     = wb_fwd_ok && (wb_rd == ex_rs2) && !ex_alu_src;
        byp_a     = wb_fwd_ok && (wb_rd == id_rs1);
        byp_b     = wb_fwd_ok && (wb_rd == id_rs2);
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: per-cycle vector table, hand sequences for halt/jump/bubble/wrap,
// and a retirement scoreboard fed at fetch time.
module tb_pipe_sequencer;

    localparam int RA_W = 3;
    localparam int W    = 1;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_JUMP = 2'b11;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            imem_valid;
    logic [1:0]      if_op;
    logic [RA_W-1:0] if_rd, if_rs1, if_rs2;
    logic            halt_req;

    logic        pc_en, pc_source, ex_alu_src, ex_alucntrl, wb_regwrite;
    logic        fwd_a, fwd_b, byp_a, byp_b, halted;
    logic [15:0] retired_cnt;
    logic [1:0]  fsm_state;

    logic        o4_pc_en, o4_pc_source, o4_ex_alu_src, o4_ex_alucntrl, o4_wb_regwrite;
    logic        o4_fwd_a, o4_fwd_b, o4_byp_a, o4_byp_b, o4_halted;
    logic [3:0]  o4_cnt;
    logic [1:0]  o4_state;

    logic [9:0]  out_vec;
    assign out_vec = {pc_en, pc_source, ex_alu_src, ex_alucntrl, wb_regwrite,
                      fwd_a, fwd_b, byp_a, byp_b, halted};

    pipe_sequencer #(.RA_W(RA_W), .CNT_W(16), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .imem_valid(imem_valid), .if_op(if_op),
        .if_rd(if_rd), .if_rs1(if_rs1), .if_rs2(if_rs2), .halt_req(halt_req),
        .pc_en(pc_en), .pc_source(pc_source), .ex_alu_src(ex_alu_src),
        .ex_alucntrl(ex_alucntrl), .wb_regwrite(wb_regwrite), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .byp_a(byp_a), .byp_b(byp_b), .halted(halted),
        .retired_cnt(retired_cnt), .fsm_state(fsm_state)
    );

    pipe_sequencer #(.RA_W(RA_W), .CNT_W(4), .ZERO_REG(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n), .imem_valid(imem_valid), .if_op(if_op),
        .if_rd(if_rd), .if_rs1(if_rs1), .if_rs2(if_rs2), .halt_req(halt_req),
        .pc_en(o4_pc_en), .pc_source(o4_pc_source), .ex_alu_src(o4_ex_alu_src),
        .ex_alucntrl(o4_ex_alucntrl), .wb_regwrite(o4_wb_regwrite), .fwd_a(o4_fwd_a),
        .fwd_b(o4_fwd_b), .byp_a(o4_byp_a), .byp_b(o4_byp_b), .halted(o4_halted),
        .retired_cnt(o4_cnt), .fsm_state(o4_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int total_pushed = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_val(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic exp_rw(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SLL);
    endfunction

    // driver
    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic halt, input logic push);
        imem_valid = v;
        if_op      = op;
        if_rd      = rd;
        if_rs1     = rs1;
        if_rs2     = rs2;
        halt_req   = halt;
        if (push) begin
            exp_q.push_back(exp_rw(op));
            total_pushed++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        repeat (n) next_cycle();
    endtask

    task automatic check_drained(input int tag);
        @(negedge clk);
        check_val("cnt16", tag, 32'(retired_cnt), 32'(total_pushed[15:0]));
        check_val("cnt4", tag, 32'(o4_cnt), 32'(total_pushed[3:0]));
        check_val("exp_q_empty", tag, 32'(exp_q.size()), 32'd0);
        next_cycle();
    endtask

    // scoreboard: each retirement pops the expected regwrite of the instruction that left WB
    logic        mon_en = 1'b0;
    logic [15:0] prev_cnt = '0;
    logic        prev_rw  = 1'b0;
    logic [W-1:0] popped;

    always @(negedge clk) begin
        if (mon_en) begin
            if (retired_cnt !== prev_cnt) begin
                check_val("retire_step", 0, 32'(retired_cnt), 32'(prev_cnt + 16'd1));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL retire_unexpected actual=cnt %0d expected=no retire", retired_cnt);
                end else begin
                    popped = exp_q.pop_front();
                    check_val("retire_regwrite", 32'(retired_cnt), 32'(prev_rw), 32'(popped));
                end
            end
            prev_cnt = retired_cnt;
            prev_rw  = wb_regwrite;
        end
    end

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       push;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [0:26];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int base;
        int exp_cnt [0:9];

        // {pc_en,pc_source,ex_alu_src,ex_alucntrl,wb_regwrite,fwd_a,fwd_b,byp_a,byp_b,halted}
        tbl[0]  = '{1'b1, OP_ADD,  3'd1, 3'd2, 3'd3, 1'b1, 10'b1000000000};
        tbl[1]  = '{1'b1, OP_ADD,  3'd4, 3'd1, 3'd1, 1'b1, 10'b1000000000};
        tbl[2]  = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[3]  = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000111000};
        tbl[4]  = '{1'b1, OP_ADD,  3'd1, 3'd2, 3'd3, 1'b1, 10'b1000100000};
        tbl[5]  = '{1'b1, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b1, 10'b1000000000};
        tbl[6]  = '{1'b1, OP_ADD,  3'd5, 3'd1, 3'd2, 1'b1, 10'b1000000000};
        tbl[7]  = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000100100};
        tbl[8]  = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[9]  = '{1'b1, OP_ADD,  3'd0, 3'd2, 3'd3, 1'b1, 10'b1000100000};
        tbl[10] = '{1'b1, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b1, 10'b1000000000};
        tbl[11] = '{1'b1, OP_ADD,  3'd5, 3'd0, 3'd2, 1'b1, 10'b1000000000};
        tbl[12] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000100000};
        tbl[13] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[14] = '{1'b1, OP_JUMP, 3'd0, 3'd0, 3'd0, 1'b1, 10'b1000100000};
        tbl[15] = '{1'b1, OP_ADD,  3'd1, 3'd2, 3'd3, 1'b0, 10'b1000000000};
        tbl[16] = '{1'b1, OP_ADD,  3'd2, 3'd1, 3'd1, 1'b0, 10'b1110000000};
        tbl[17] = '{1'b1, OP_ADD,  3'd6, 3'd2, 3'd3, 1'b1, 10'b1000000000};
        tbl[18] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[19] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[20] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000100000};
        tbl[21] = '{1'b1, OP_ADD,  3'd3, 3'd1, 3'd2, 1'b1, 10'b1000000000};
        tbl[22] = '{1'b1, OP_SLL,  3'd7, 3'd3, 3'd3, 1'b1, 10'b1000000000};
        tbl[23] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};
        tbl[24] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0011110000};
        tbl[25] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000100000};
        tbl[26] = '{1'b0, OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 10'b0000000000};

        // reset held with a valid instruction presented
        reset_n = 1'b0;
        drive(1'b1, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("reset_outputs", i, 32'(out_vec), 32'd0);
            check_val("reset_cnt", i, 32'(retired_cnt), 32'd0);
            @(posedge clk);
        end
        #1;
        reset_n  = 1'b1;
        prev_cnt = '0;
        prev_rw  = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);
        check_val("idle_pc_en", 0, 32'(pc_en), 32'd0);
        check_val("idle_state", 0, 32'(fsm_state), 32'd0);
        next_cycle();
        exp_q.push_back(1'b0);
        total_pushed++;
        @(negedge clk);
        check_val("first_pc_en", 0, 32'(pc_en), 32'd1);
        next_cycle();

        // vector table: forwarding, bypass, r0, jump flush, SLL operand B
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b0, tbl[i].push);
            @(negedge clk);
            check_val("vec", i, 32'(out_vec), 32'(tbl[i].exp));
            next_cycle();
        end
        check_drained(1);

        // halt during an ADD stream
        drive(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("halt_pc_en_run", 0, 32'(pc_en), 32'd1);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        check_val("halt_pc_en_run", 1, 32'(pc_en), 32'd1);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!halted && n < 10) begin
            check_val("drain_pc_en", n, 32'(pc_en), 32'd0);
            next_cycle();
            @(negedge clk);
            n++;
        end
        check_val("halted_reached", 0, 32'(halted), 32'd1);
        check_val("drain_cycles", 0, 32'(n), 32'd4);
        check_val("halted_pc_en", 0, 32'(pc_en), 32'd0);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("halted_hold", 0, 32'({halted, pc_en}), 32'b10);
        next_cycle();
        @(negedge clk);
        check_val("resume_run", 0, 32'({halted, pc_en}), 32'b01);
        next_cycle();
        idle_cycles(4);
        check_drained(2);

        // jump reaching EX while draining; halt_req dropped mid-drain
        drive(1'b1, OP_JUMP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        check_val("dj_fetch", 0, 32'(pc_en), 32'd1);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("dj_redirect", 0, 32'({pc_en, pc_source}), 32'b11);
        next_cycle();
        @(negedge clk);
        check_val("dj_no_fetch", 0, 32'({pc_en, pc_source, wb_regwrite}), 32'b000);
        next_cycle();
        @(negedge clk);
        check_val("dj_flushed", 0, 32'({wb_regwrite, halted}), 32'b00);
        next_cycle();
        @(negedge clk);
        check_val("dj_halted", 0, 32'({halted, pc_en}), 32'b10);
        next_cycle();
        drive(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("dj_resume", 0, 32'({halted, pc_en}), 32'b01);
        next_cycle();
        idle_cycles(4);
        check_drained(3);

        // three fetch bubbles keep the retire count flat
        base = total_pushed;
        exp_cnt = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 3};
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 1 || i == 5)
                drive(1'b1, OP_ADD, 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 1'b0, 1'b1);
            else
                drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            check_val("bubble_cnt", i, 32'(retired_cnt), 32'(base + exp_cnt[i]));
            next_cycle();
        end
        idle_cycles(4);
        check_drained(4);

        // narrow counter wraps to zero
        k = ((16 - (total_pushed % 16)) % 16) + 16;
        for (int i = 0; i < k; i++) begin
            drive(1'b1, ($urandom_range(0, 1) == 1) ? OP_NOP : OP_SLL, 3'd0,
                  3'd0, 3'd0, 1'b0, 1'b1);
            next_cycle();
        end
        idle_cycles(4);
        @(negedge clk);
        check_val("cnt4_wrap_zero", 0, 32'(o4_cnt), 32'd0);
        next_cycle();
        check_drained(5);

        // asynchronous reset mid-stream
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
            next_cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_reset_outputs", 0, 32'(out_vec), 32'd0);
        check_val("async_reset_cnt", 0, 32'(retired_cnt), 32'd0);
        check_val("async_reset_cnt4", 0, 32'(o4_cnt), 32'd0);
        check_val("async_reset_state", 0, 32'(fsm_state), 32'd0);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
